// File: rtl/aemb_wb_ram_slave_if.sv
// WISHBONE classic bus bundle between the core's dwb_*/iwb_* master port
// and a RAM slave. Signal names follow the slave's point of view.
interface aemb_wb_ram_slave_if #(
  parameter int ASIZ = 32
);
  logic            wb_stb_i;
  logic            wb_we_i;
  logic [3:0]      wb_sel_i;
  logic [ASIZ-1:0] wb_adr_i;
  logic [31:0]     wb_dat_i;
  logic [31:0]     wb_dat_o;
  logic            wb_ack_o;

  modport slave (
    input  wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
    output wb_dat_o, wb_ack_o
  );

  modport master (
    output wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/aemb_wb_ram_slave.sv
// WISHBONE classic slave on-chip RAM with programmable wait states.
// Byte-lane writes, full-word reads, one access per WAIT+2 cycles.
// Optional address decode: define AEMB_WB_RAM_DECODE_EN to drop writes and
// return zero for reads outside [BASE, BASE + 4*2^AW). Without it, the
// window aliases modulo 4*2^AW bytes.
module aemb_wb_ram_slave #(
  parameter int              ASIZ = 32,
  parameter int              AW   = 10,
  parameter int              WAIT = 0,
  parameter logic [ASIZ-1:0] BASE = '0
) (
  input  logic                  sys_clk_i,
  input  logic                  sys_rst_i,
  aemb_wb_ram_slave_if.slave    wb
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  localparam logic [3:0] WAIT_M1 = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [3:0]      r_cnt;
  logic            r_we;
  logic [3:0]      r_sel;
  logic [ASIZ-1:0] r_adr;
  logic [31:0]     r_dat;
  logic [31:0]     r_rdat;

  logic            w_idle;
  logic            w_accept;
  logic            w_enter_ack;
  logic            w_cur_we;
  logic [3:0]      w_cur_sel;
  logic [ASIZ-1:0] w_cur_adr;
  logic [31:0]     w_cur_dat;
  logic [AW-1:0]   w_word;
  logic            w_hit;
  logic            w_do_write;
  logic [31:0]     w_rd_word;

  assign w_idle   = (r_state == S_IDLE);
  assign w_accept = w_idle && wb.wb_stb_i;

  // With WAIT=0 the edge that accepts the cycle also enters ACK, so the
  // access must use the live bus values; otherwise the latched copies.
  assign w_cur_we  = w_idle ? wb.wb_we_i  : r_we;
  assign w_cur_sel = w_idle ? wb.wb_sel_i : r_sel;
  assign w_cur_adr = w_idle ? wb.wb_adr_i : r_adr;
  assign w_cur_dat = w_idle ? wb.wb_dat_i : r_dat;

  // Offset from the window base, in words, truncated to the RAM depth.
  assign w_word = AW'((w_cur_adr - BASE) >> 2);

`ifdef AEMB_WB_RAM_DECODE_EN
  logic w_in_range;
  logic r_hit;

  assign w_in_range = (w_cur_adr >= BASE) && (((w_cur_adr - BASE) >> (AW + 2)) == '0);
  assign w_hit      = w_idle ? w_in_range : r_hit;

  // Window decision is taken once, when the cycle is accepted.
  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i)    r_hit <= 1'b0;
    else if (w_accept) r_hit <= w_in_range;
  end
`else
  assign w_hit = 1'b1;
`endif

  // FSM state register.
  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) r_state <= S_IDLE;
    else            r_state <= w_state_nxt;
  end

  // Next-state: a dropped strobe in WAIT aborts even when the count expires.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (wb.wb_stb_i) w_state_nxt = (WAIT == 0) ? S_ACK : S_WAIT;
      S_WAIT: begin
        if (!wb.wb_stb_i)     w_state_nxt = S_IDLE;
        else if (r_cnt == '0) w_state_nxt = S_ACK;
      end
      S_ACK:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_enter_ack = (w_state_nxt == S_ACK);
  assign w_do_write  = w_enter_ack && w_cur_we && w_hit;

  // Latch the request at acceptance and run the wait-state countdown.
  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      r_cnt <= '0;
      r_we  <= 1'b0;
      r_sel <= '0;
      r_adr <= '0;
      r_dat <= '0;
    end else if (w_accept) begin
      r_cnt <= WAIT_M1;
      r_we  <= wb.wb_we_i;
      r_sel <= wb.wb_sel_i;
      r_adr <= wb.wb_adr_i;
      r_dat <= wb.wb_dat_i;
    end else if ((r_state == S_WAIT) && wb.wb_stb_i && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // One byte-wide RAM per lane so each sel bit is a plain write enable.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] r_mem [0:(1<<AW)-1];

    // Lane write on the edge that enters ACK; contents survive reset.
    always_ff @(posedge sys_clk_i) begin
      if (w_do_write && w_cur_sel[gi]) r_mem[w_word] <= w_cur_dat[gi*8 +: 8];
    end

    assign w_rd_word[gi*8 +: 8] = r_mem[w_word];
  end

  // Read data register: loaded on reads entering ACK, held otherwise.
  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i)                   r_rdat <= '0;
    else if (w_enter_ack && !w_cur_we) r_rdat <= w_hit ? w_rd_word : 32'h0000_0000;
  end

  assign wb.wb_ack_o = (r_state == S_ACK);
  assign wb.wb_dat_o = r_rdat;

endmodule
